// File: rtl/example_mul_mac_pipe.sv
// Parametrised mixed-sign multiplier with a retimable product pipeline, an optional
// framed accumulator and a saturating or truncating signed output stage.
module example_mul_mac_pipe #(
  parameter int A_WIDTH   = 6,
  parameter int B_WIDTH   = 14,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int NUM_STAGE = 3,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 20,
  parameter int SATURATE  = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic        [A_WIDTH-1:0]   din0,
  input  logic        [B_WIDTH-1:0]   din1,
  input  logic                        acc_en,
  input  logic                        acc_first,
  input  logic                        acc_last,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam int AEW  = A_WIDTH + ((A_SIGNED == 0) ? 1 : 0);
  localparam int BEW  = B_WIDTH + ((B_SIGNED == 0) ? 1 : 0);
  localparam int PW   = AEW + BEW;
  localparam int LAST = NUM_STAGE - 1;

  // Fit a full-width value into OUT_WIDTH; returns {ovf, dout}.
  function automatic logic [OUT_WIDTH:0] fit(input logic signed [ACC_WIDTH-1:0] x);
    logic                 hi_ones;
    logic                 hi_zeros;
    logic                 fits;
    logic [OUT_WIDTH-1:0] v;
    hi_ones  = &x[ACC_WIDTH-1:OUT_WIDTH-1];
    hi_zeros = ~|x[ACC_WIDTH-1:OUT_WIDTH-1];
    fits     = hi_ones | hi_zeros;
    v        = x[OUT_WIDTH-1:0];
    if ((SATURATE != 0) && !fits) begin
      v = x[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    return {~fits, v};
  endfunction

  logic signed [AEW-1:0]       a_ext_p0;
  logic signed [BEW-1:0]       b_ext_p0;
  logic signed [PW-1:0]        prod_p0;
  logic signed [ACC_WIDTH-1:0] prod_acc_p0;

  // Entry: sign/zero-extend operands, full-width signed product, widen to accumulator
  generate
    if (A_SIGNED != 0) begin : g_a_signed
      assign a_ext_p0 = $signed(din0);
    end else begin : g_a_unsigned
      assign a_ext_p0 = $signed({1'b0, din0});
    end
    if (B_SIGNED != 0) begin : g_b_signed
      assign b_ext_p0 = $signed(din1);
    end else begin : g_b_unsigned
      assign b_ext_p0 = $signed({1'b0, din1});
    end
  endgenerate

  assign prod_p0     = PW'(a_ext_p0) * PW'(b_ext_p0);
  assign prod_acc_p0 = ACC_WIDTH'(prod_p0);

  logic signed [ACC_WIDTH-1:0] prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]        vld_q;
  logic [NUM_STAGE-1:0]        en_q;
  logic [NUM_STAGE-1:0]        first_q;
  logic [NUM_STAGE-1:0]        last_q;

  // Stages 0..NUM_STAGE-1: product and framing travel together, left for retiming into the DSP
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      prod_q[0]  <= prod_acc_p0;
      en_q[0]    <= acc_en;
      first_q[0] <= acc_first;
      last_q[0]  <= acc_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        en_q[i]    <= en_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
    end else if (ce) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        out_valid_q;
  logic                        out_valid_d;
  logic [OUT_WIDTH-1:0]        dout_q;
  logic [OUT_WIDTH-1:0]        dout_d;
  logic                        ovf_q;
  logic                        ovf_d;

  // Output stage: plain multiply beats bypass acc so they can interleave inside an open sum
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    acc_nxt     = first_q[LAST] ? prod_q[LAST] : acc_q + prod_q[LAST];
    if (vld_q[LAST]) begin
      if (en_q[LAST]) begin
        acc_d = acc_nxt;
        if (last_q[LAST]) begin
          out_valid_d     = 1'b1;
          {ovf_d, dout_d} = fit(acc_nxt);
        end
      end else begin
        out_valid_d     = 1'b1;
        {ovf_d, dout_d} = fit(prod_q[LAST]);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_example_mul_mac_pipe.sv
// Bench for example_mul_mac_pipe: default, truncating and signed-A instances share one
// stimulus stream and are checked every cycle against a beat-level arithmetic model.
module tb_example_mul_mac_pipe;

  logic              clk = 1'b0;
  logic              rst, ce, vld, en, fst, lst;
  logic [5:0]        a;
  logic [13:0]       b;
  logic [2:0]        ov_w;
  logic [2:0][19:0]  d_w;
  logic [2:0]        o_w;

  always #5 clk = ~clk;

  example_mul_mac_pipe u_dflt (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(vld), .din0(a), .din1(b),
    .acc_en(en), .acc_first(fst), .acc_last(lst),
    .out_valid(ov_w[0]), .dout(d_w[0]), .ovf(o_w[0]));

  example_mul_mac_pipe #(.SATURATE(0)) u_trunc (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(vld), .din0(a), .din1(b),
    .acc_en(en), .acc_first(fst), .acc_last(lst),
    .out_valid(ov_w[1]), .dout(d_w[1]), .ovf(o_w[1]));

  example_mul_mac_pipe #(.A_SIGNED(1)) u_asgn (
    .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(vld), .din0(a), .din1(b),
    .acc_en(en), .acc_first(fst), .acc_last(lst),
    .out_valid(ov_w[2]), .dout(d_w[2]), .ovf(o_w[2]));

  typedef struct packed {
    int          due;
    logic [5:0]  a;
    logic [13:0] b;
    logic        en, f, l;
  } beat_t;

  beat_t       bq[$];
  int          cecnt = 0;
  int          macc[3];
  logic        exp_ov = 1'b0;
  logic [19:0] exp_d[3];
  logic        exp_o[3];
  int          n_assert = 0;
  int          n_fail = 0;

  // Instance 2 treats din0 as signed; din1 is always signed.
  function automatic longint mprod(input int inst, input logic [5:0] av, input logic [13:0] bv);
    longint x, y;
    x = (inst == 2) ? longint'($signed(av)) : longint'(av);
    y = longint'($signed(bv));
    return x * y;
  endfunction

  // Instance 1 truncates, the others clamp to the signed 20-bit range.
  function automatic logic [20:0] mfit(input int inst, input longint x);
    logic [20:0] r;
    r[19:0] = x[19:0];
    r[20]   = (x > 524287) || (x < -524288);
    if (inst != 1 && r[20]) r[19:0] = (x < 0) ? 20'h80000 : 20'h7FFFF;
    return r;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, expv);
    end
  endtask

  task automatic step(input bit c, input bit r, input bit v, input logic [5:0] av,
                      input logic [13:0] bv, input bit e, input bit f, input bit l);
    beat_t       bt;
    longint      p;
    logic [20:0] fr;
    @(negedge clk);
    ce = c; rst = r; vld = v; a = av; b = bv; en = e; fst = f; lst = l;
    if (r) begin
      bq.delete();
      exp_ov = 1'b0;
      for (int i = 0; i < 3; i++) begin
        macc[i] = 0; exp_d[i] = '0; exp_o[i] = 1'b0;
      end
    end else if (c) begin
      cecnt++;
      if (v) bq.push_back('{due: cecnt + 3, a: av, b: bv, en: e, f: f, l: l});
      exp_ov = 1'b0;
      if (bq.size() > 0 && bq[0].due == cecnt) begin
        bt = bq.pop_front();
        for (int i = 0; i < 3; i++) begin
          p = mprod(i, bt.a, bt.b);
          if (!bt.en) begin
            fr = mfit(i, p);
            exp_ov = 1'b1; exp_d[i] = fr[19:0]; exp_o[i] = fr[20];
          end else begin
            macc[i] = bt.f ? int'(p) : macc[i] + int'(p);
            if (bt.l) begin
              fr = mfit(i, longint'(macc[i]));
              exp_ov = 1'b1; exp_d[i] = fr[19:0]; exp_o[i] = fr[20];
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, {31'b0, ov_w[i]}, {31'b0, exp_ov});
      chk("dout", i, {12'b0, d_w[i]}, {12'b0, exp_d[i]});
      chk("ovf", i, {31'b0, o_w[i]}, {31'b0, exp_o[i]});
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 6'd0, 14'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_out();
    int k = 0;
    while (ov_w[0] !== 1'b1 && k < 8) begin
      idle();
      k++;
    end
    chk("result_timeout", 0, {31'b0, ov_w[0]}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; vld = 1'b0; a = '0; b = '0; en = 1'b0; fst = 1'b0; lst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      macc[i] = 0; exp_d[i] = '0; exp_o[i] = 1'b0;
    end
    step(1'b0, 1'b1, 1'b0, 6'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 6'd0, 14'd0, 1'b0, 1'b0, 1'b0);

    // Plain multiply, largest-magnitude default product
    step(1'b1, 1'b0, 1'b1, 6'd63, 14'h2000, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    chk("mul_latency_early", 0, {31'b0, ov_w[0]}, 32'd0);
    idle();
    chk("mul_dout", 0, {12'b0, d_w[0]}, {12'b0, 20'(-516096)});
    chk("mul_ovf", 0, {31'b0, o_w[0]}, 32'd0);

    // Back-to-back multiplies
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 6'(i + 1), 14'(i * 3 + 5), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle();

    // Three-beat sum
    step(1'b1, 1'b0, 1'b1, 6'd3, 14'd100, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'd2, 14'(-50), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'd1, 14'd7, 1'b1, 1'b0, 1'b1);
    wait_out();
    chk("sum_dout", 0, {12'b0, d_w[0]}, 32'd207);

    // Two-beat overflowing sum: clamp vs truncate
    step(1'b1, 1'b0, 1'b1, 6'd63, 14'h2000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'd63, 14'h2000, 1'b1, 1'b0, 1'b1);
    wait_out();
    chk("sat_dout", 0, {12'b0, d_w[0]}, {12'b0, 20'h80000});
    chk("sat_ovf", 0, {31'b0, o_w[0]}, 32'd1);
    chk("trunc_dout", 1, {12'b0, d_w[1]}, {12'b0, 20'h04000});
    chk("trunc_ovf", 1, {31'b0, o_w[1]}, 32'd1);

    // Operand A signedness
    step(1'b1, 1'b0, 1'b1, 6'h3F, 14'd100, 1'b0, 1'b0, 1'b0);
    wait_out();
    chk("a_unsigned", 0, {12'b0, d_w[0]}, 32'd6300);
    chk("a_signed", 2, {12'b0, d_w[2]}, {12'b0, 20'(-100)});

    // Stream under a stalling clock enable
    for (int i = 0; i < 24; i++)
      step((i % 3) == 0, 1'b0, 1'b1, 6'($urandom), 14'($urandom), 1'($urandom_range(0, 1)),
           (i % 4) == 0, (i % 4) == 3);
    for (int i = 0; i < 6; i++) idle();

    // Reset with a sum in flight, then a fresh single-beat sum
    step(1'b1, 1'b0, 1'b1, 6'd1, 14'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 6'd3, 14'd4, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 6'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_clears_valid", 0, {31'b0, ov_w[0]}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 6'd5, 14'd5, 1'b1, 1'b1, 1'b1);
    wait_out();
    chk("post_rst_dout", 0, {12'b0, d_w[0]}, 32'd25);

    // Random mix of stalls, resets, sums and plain multiplies
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           6'($urandom), 14'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    for (int i = 0; i < 6; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
